// File: rtl/dmg_bus_pkg.sv
// Shared definitions for the SM83 external-bus target responder.
package dmg_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RREQ   = 3'd1,
        RWAIT  = 3'd2,
        RDRIVE = 3'd3,
        WCAP   = 3'd4,
        WREQ   = 3'd5
    } state_t;

    // Value returned on a read the backend never answered.
    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

    // Strobe history comes out of reset low; the primed flag keeps a strobe
    // that is already high at reset release from counting as a new start.
    localparam logic STROBE_HIST_RESET = 1'b0;

    // Timeout counter width, enough for the largest TIMEOUT (255).
    localparam int unsigned TIMEOUT_WIDTH = 8;

    // Rising edge of a qualified strobe against its registered history.
    function automatic logic strobe_rise(input logic prev, input logic cur, input logic primed);
        return primed & cur & ~prev;
    endfunction

endpackage

// File: rtl/dmg_bus_timeout.sv
// Backend-response timeout: cleared by load, counts while run is high and
// flags expiry on the TIMEOUT-th cycle of running.
module dmg_bus_timeout
    import dmg_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] STEP  = TIMEOUT_WIDTH'(1);

    logic [TIMEOUT_WIDTH-1:0] count;

    // Cycle counter, saturating at the limit so it cannot wrap while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (run && count != LIMIT) begin
            count <= count + STEP;
        end
    end

    // Expiry is only meaningful while the wait is running.
    always_comb begin
        expired = run && (count == LIMIT);
    end

endmodule

// File: rtl/dmg_bus_responder.sv
// Target side of the SM83 external memory bus: decodes an address window,
// forwards accesses to a valid/ready backend port and drives read data back.
module dmg_bus_responder
    import dmg_bus_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'h0000,
    parameter logic [15:0] MASK     = 16'h0000,
    parameter int unsigned TIMEOUT  = 8,
    parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] AddrBus,
    input  logic        MREQ,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  DataIn,
    output logic [7:0]  DataOut,
    output logic        DataOE,
    output logic        req_valid,
    output logic        req_we,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        overrun
);

    state_t     state;
    state_t     next_state;
    logic       rd_act;
    logic       wr_act;
    logic       rd_hist;
    logic       wr_hist;
    logic       primed;
    logic       rd_start;
    logic       wr_start;
    logic       hit;
    logic       expired;
    logic       read_done;
    logic       take_rsp;
    logic [7:0] wsample;

    // Qualified strobes, start detection and window decode.
    always_comb begin
        rd_act   = MREQ & RD;
        wr_act   = MREQ & WR;
        rd_start = strobe_rise(rd_hist, rd_act, primed);
        wr_start = strobe_rise(wr_hist, wr_act, primed);
        hit      = (AddrBus & MASK) == BASE;
    end

    dmg_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RESET),
        .load    (state == IDLE),
        .run     ((state == RREQ) || (state == RWAIT)),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a read whose strobe already dropped skips RDRIVE.
    always_comb begin
        next_state = state;
        read_done  = 1'b0;
        take_rsp   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start && hit) begin
                    next_state = RREQ;
                end else if (wr_start && hit) begin
                    next_state = WCAP;
                end
            end
            RREQ: begin
                if (expired) begin
                    read_done  = 1'b1;
                    next_state = rd_act ? RDRIVE : IDLE;
                end else if (req_ready) begin
                    next_state = RWAIT;
                end
            end
            RWAIT: begin
                if (rsp_valid || expired) begin
                    read_done  = 1'b1;
                    take_rsp   = rsp_valid;
                    next_state = rd_act ? RDRIVE : IDLE;
                end
            end
            RDRIVE: begin
                if (!rd_act) begin
                    next_state = IDLE;
                end
            end
            WCAP: begin
                if (!wr_act) begin
                    next_state = WREQ;
                end
            end
            WREQ: begin
                if (req_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (state != IDLE);
        req_valid = (state == RREQ) || (state == WREQ);
        req_we    = (state == WREQ);
    end

    // Datapath: strobe history, latched request fields, read data and drive enable.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_hist   <= STROBE_HIST_RESET;
            wr_hist   <= STROBE_HIST_RESET;
            primed    <= 1'b0;
            overrun   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            wsample   <= '0;
            DataOut   <= '0;
            DataOE    <= 1'b0;
        end else begin
            rd_hist <= rd_act;
            wr_hist <= wr_act;
            primed  <= 1'b1;

            if (((state != IDLE) && (rd_start || wr_start)) || (rd_start && wr_start)) begin
                overrun <= 1'b1;
            end

            if ((state == IDLE) && (next_state != IDLE)) begin
                req_addr <= AddrBus;
            end

            if ((next_state == WCAP) && wr_act) begin
                wsample <= DataIn;
            end

            if ((state == WCAP) && !wr_act) begin
                req_wdata <= wsample;
            end

            // DataOut is a bus keeper: updated on completion, never cleared.
            if (read_done) begin
                DataOut <= take_rsp ? rsp_rdata : OPEN_BUS;
                DataOE  <= rd_act;
            end else if ((state == RDRIVE) && !rd_act) begin
                DataOE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmg_bus_responder.sv
// Self-checking bench for dmg_bus_responder: directed scenarios plus random
// read/write transactions against a cycle-timing reference model.
module tb_dmg_bus_responder;

    localparam int unsigned TMO  = 8;
    localparam logic [7:0]  OPEN = 8'hFF;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] AddrBus;
    logic        MREQ, RD, WR;
    logic [7:0]  DataIn;
    logic [7:0]  DataOut;
    logic        DataOE;
    logic        req_valid, req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy, overrun;

    logic        mreq_w;
    logic [7:0]  DataOut_w;
    logic        DataOE_w, req_valid_w, req_we_w, busy_w, overrun_w;
    logic [15:0] req_addr_w;
    logic [7:0]  req_wdata_w;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  prev_out;
    logic        ovr_exp;

    always #5 CLK = ~CLK;

    dmg_bus_responder #(
        .BASE     (16'h0000),
        .MASK     (16'h0000),
        .TIMEOUT  (TMO),
        .OPEN_BUS (OPEN)
    ) dut (
        .CLK(CLK), .RESET(RESET), .AddrBus(AddrBus), .MREQ(MREQ), .RD(RD), .WR(WR),
        .DataIn(DataIn), .DataOut(DataOut), .DataOE(DataOE), .req_valid(req_valid),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .overrun(overrun)
    );

    dmg_bus_responder #(
        .BASE     (16'hA000),
        .MASK     (16'hE000),
        .TIMEOUT  (TMO),
        .OPEN_BUS (OPEN)
    ) dut_w (
        .CLK(CLK), .RESET(RESET), .AddrBus(AddrBus), .MREQ(mreq_w), .RD(RD), .WR(WR),
        .DataIn(DataIn), .DataOut(DataOut_w), .DataOE(DataOE_w), .req_valid(req_valid_w),
        .req_we(req_we_w), .req_addr(req_addr_w), .req_wdata(req_wdata_w), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy_w), .overrun(overrun_w)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        MREQ = 1'b0; RD = 1'b0; WR = 1'b0; mreq_w = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    // Read: edge 0 sees the start; ready from edge acc; response from rsp_at.
    // The access completes at the response or at edge TMO, whichever is first.
    task automatic do_read(input logic [15:0] a, input logic [7:0] d, input int unsigned dr,
                           input int unsigned ds, input bit has_rsp, input int unsigned hold,
                           input bit early, input int unsigned glitch, input bit with_wr);
        int unsigned acc, rsp_at, done, f, fin, rv_end;
        logic [7:0]  val;
        logic        lvl;
        acc    = 1 + dr;
        rsp_at = acc + 1 + ds;
        if (acc < TMO && has_rsp && rsp_at <= TMO) begin
            done = rsp_at; val = d;
        end else begin
            done = TMO; val = OPEN;
        end
        f      = early ? 1 + (hold % done) : done + hold;
        fin    = (f <= done) ? done : f;
        rv_end = (acc < TMO) ? acc : TMO;
        for (int unsigned k = 0; k <= fin + 1; k++) begin
            lvl       = (k < f) && !(glitch != 0 && k == glitch);
            MREQ      = lvl;
            RD        = lvl;
            WR        = with_wr & lvl;
            AddrBus   = a;
            req_ready = (k >= acc);
            rsp_valid = has_rsp && (k >= rsp_at);
            rsp_rdata = rsp_valid ? d : 8'($urandom);
            tick();
            if (with_wr && k == 0) ovr_exp = 1'b1;
            if (glitch != 0 && k == glitch + 1) ovr_exp = 1'b1;
            chk("rd_busy",      16'(busy),      16'(k < fin));
            chk("rd_oe",        16'(DataOE),    16'(k >= done && k < f));
            chk("rd_dataout",   16'(DataOut),   16'((k >= done) ? val : prev_out));
            chk("rd_req_valid", 16'(req_valid), 16'(k < rv_end));
            chk("rd_req_we",    16'(req_we),    16'(0));
            chk("rd_overrun",   16'(overrun),   16'(ovr_exp));
            if (k < rv_end) chk("rd_req_addr", req_addr, a);
        end
        prev_out = val;
        idle(1);
    endtask

    // Write: WR seen low first at edge wlen; the last DataIn sampled while WR
    // was high becomes req_wdata; ready arrives dw cycles after req_valid.
    task automatic do_write(input logic [15:0] a, input int unsigned wlen, input int unsigned dw,
                            input logic [7:0] last);
        int unsigned acc;
        logic        vld;
        acc = wlen + 1 + dw;
        for (int unsigned k = 0; k <= acc + 1; k++) begin
            MREQ      = (k < wlen);
            WR        = (k < wlen);
            RD        = 1'b0;
            AddrBus   = a;
            DataIn    = (k + 1 == wlen) ? last : 8'($urandom);
            req_ready = (k >= acc);
            rsp_valid = 1'b0;
            rsp_rdata = 8'($urandom);
            tick();
            vld = (k >= wlen) && (k < acc);
            chk("wr_busy",      16'(busy),      16'(k < acc));
            chk("wr_req_valid", 16'(req_valid), 16'(vld));
            chk("wr_req_we",    16'(req_we),    16'(vld));
            chk("wr_oe",        16'(DataOE),    16'(0));
            chk("wr_dataout",   16'(DataOut),   16'(prev_out));
            chk("wr_overrun",   16'(overrun),   16'(ovr_exp));
            if (vld) begin
                chk("wr_req_addr",  req_addr,       a);
                chk("wr_req_wdata", 16'(req_wdata), 16'(last));
            end
        end
        idle(1);
    endtask

    task automatic random_traffic(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_read(16'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                        $urandom_range(0, 3) != 0, $urandom_range(1, 4), $urandom_range(0, 3) == 0, 0, 0);
            else
                do_write(16'($urandom), $urandom_range(1, 4), $urandom_range(0, 3), 8'($urandom));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; AddrBus = '0; MREQ = 1'b0; RD = 1'b0; WR = 1'b0; mreq_w = 1'b0;
        DataIn = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        prev_out = 8'h00; ovr_exp = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("rst_dataout",   16'(DataOut),   16'h0000);
        chk("rst_oe",        16'(DataOE),    16'h0000);
        chk("rst_req_valid", 16'(req_valid), 16'h0000);
        chk("rst_req_we",    16'(req_we),    16'h0000);
        chk("rst_req_addr",  req_addr,       16'h0000);
        chk("rst_req_wdata", 16'(req_wdata), 16'h0000);
        chk("rst_busy",      16'(busy),      16'h0000);
        chk("rst_overrun",   16'(overrun),   16'h0000);
        @(negedge CLK);
        RESET = 1'b0;
        idle(2);

        // Minimum-latency read, write with delayed ready, read timeout.
        do_read(16'hC000, 8'h3C, 0, 0, 1, 1, 0, 0, 0);
        do_write(16'h8010, 3, 3, 8'hA5);
        do_read(16'h4123, 8'h11, 0, 0, 0, 3, 0, 0, 0);

        // Address window on the second instance: miss, then a hit at the top.
        mreq_w = 1'b1; RD = 1'b1; AddrBus = 16'h4000;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 8'h77;
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            chk("win_miss_valid", 16'(req_valid_w), 16'h0000);
            chk("win_miss_oe",    16'(DataOE_w),    16'h0000);
            chk("win_miss_busy",  16'(busy_w),      16'h0000);
        end
        idle(2);
        mreq_w = 1'b1; RD = 1'b1; AddrBus = 16'hBFFF;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 8'hC9;
        tick();
        chk("win_hit_valid", 16'(req_valid_w), 16'h0001);
        chk("win_hit_addr",  req_addr_w,       16'hBFFF);
        tick();
        chk("win_hit_oe1",   16'(DataOE_w),    16'h0000);
        tick();
        chk("win_hit_oe2",   16'(DataOE_w),    16'h0001);
        chk("win_hit_data",  16'(DataOut_w),   16'h00C9);
        mreq_w = 1'b0; RD = 1'b0;
        tick();
        chk("win_hit_drop",  16'(DataOE_w),    16'h0000);
        chk("win_hit_idle",  16'(busy_w),      16'h0000);
        idle(2);

        random_traffic(20);

        // Second RD start while waiting for the response.
        do_read(16'hD00D, 8'h99, 0, 4, 1, 2, 0, 2, 0);
        random_traffic(10);

        // Asynchronous reset in RDRIVE, then release with RD still high.
        MREQ = 1'b1; RD = 1'b1; AddrBus = 16'hC000;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 8'h5A;
        repeat (3) tick();
        chk("rdrive_oe",   16'(DataOE),  16'h0001);
        chk("rdrive_data", 16'(DataOut), 16'h005A);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_oe",        16'(DataOE),    16'h0000);
        chk("async_rst_dataout",   16'(DataOut),   16'h0000);
        chk("async_rst_busy",      16'(busy),      16'h0000);
        chk("async_rst_req_valid", 16'(req_valid), 16'h0000);
        chk("async_rst_req_addr",  req_addr,       16'h0000);
        chk("async_rst_overrun",   16'(overrun),   16'h0000);
        ovr_exp = 1'b0; prev_out = 8'h00;
        @(negedge CLK);
        RESET = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk("release_busy",  16'(busy),      16'h0000);
            chk("release_valid", 16'(req_valid), 16'h0000);
        end
        idle(2);

        // RD and WR rising together: served as a read, overrun raised.
        do_read(16'h2222, 8'h42, 1, 1, 1, 2, 0, 0, 1);
        random_traffic(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
